// File: rtl/hub75_pkg.sv
// Shared types and default geometry for the HUB75 panel-side receiver.
package hub75_pkg;

   localparam int unsigned HUB75_WIDTH   = 64;
   localparam int unsigned HUB75_XBITS   = 6;
   localparam int unsigned HUB75_ROWBITS = 5;

   typedef logic [2:0] rgb_t;  // {B,G,R}

   typedef struct packed {
      rgb_t rgb1;
      rgb_t rgb0;
   } pix_pair_t;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_DRAIN = 1'b1
   } state_t;

endpackage

// File: rtl/hub75_sync_edge.sv
// 2-FF synchronizer with a third stage for rising-edge detection.
module hub75_sync_edge
   import hub75_pkg::*;
#(
   parameter int unsigned W = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] i_d,
   output logic [W-1:0] o_q,
   output logic [W-1:0] o_rise_c
);

   logic [W-1:0] r_s1;
   logic [W-1:0] r_s2;
   logic [W-1:0] r_s3;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1 <= '0;
         r_s2 <= '0;
         r_s3 <= '0;
      end else begin
         r_s1 <= i_d;
         r_s2 <= r_s1;
         r_s3 <= r_s2;
      end
   end

   assign o_q      = r_s2;
   assign o_rise_c = r_s2 & ~r_s3;

endmodule

// File: rtl/hub75_rx.sv
// HUB75 panel emulator: models the column shift register and streams each latched line as pixel writes.
module hub75_rx
   import hub75_pkg::*;
#(
   parameter int unsigned WIDTH   = HUB75_WIDTH,
   parameter int unsigned XBITS   = HUB75_XBITS,
   parameter int unsigned ROWBITS = HUB75_ROWBITS
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               sclk,
   input  logic               latch,
   input  logic               blank,
   input  logic [ROWBITS-1:0] addry,
   input  logic [2:0]         rgb0,
   input  logic [2:0]         rgb1,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [XBITS-1:0]   out_x,
   output logic [ROWBITS-1:0] out_y,
   output logic [2:0]         out_rgb0,
   output logic [2:0]         out_rgb1,
   output logic               busy,
   output logic               blank_s,
   output logic               frame_start,
   output logic               overrun,
   output logic               short_line
);

   localparam int unsigned CBITS = $clog2(WIDTH + 1);
   localparam int unsigned DW    = 1 + ROWBITS + 6;

   logic               w_sclk_rise;
   logic               w_latch_rise;
   logic               w_sclk_q_unused;
   logic               w_latch_q_unused;
   logic [DW-1:0]      w_data_q;
   logic [DW-1:0]      w_data_rise_unused;
   logic               w_blank;
   logic [ROWBITS-1:0] w_addry;
   pix_pair_t          w_pair;

   hub75_sync_edge #(.W(1)) u_sync_sclk (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_d      (sclk),
      .o_q      (w_sclk_q_unused),
      .o_rise_c (w_sclk_rise)
   );

   hub75_sync_edge #(.W(1)) u_sync_latch (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_d      (latch),
      .o_q      (w_latch_q_unused),
      .o_rise_c (w_latch_rise)
   );

   // Data shares the strobe's latency, so w_data_q is aligned with the detected edges.
   hub75_sync_edge #(.W(DW)) u_sync_data (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_d      ({blank, addry, rgb1, rgb0}),
      .o_q      (w_data_q),
      .o_rise_c (w_data_rise_unused)
   );

   assign w_blank = w_data_q[DW-1];
   assign w_addry = w_data_q[6 +: ROWBITS];
   assign w_pair  = pix_pair_t'(w_data_q[5:0]);

   pix_pair_t [WIDTH-1:0] r_sr;
   pix_pair_t [WIDTH-1:0] w_sr_next;
   pix_pair_t [WIDTH-1:0] r_line;
   logic [CBITS-1:0]      r_cnt;
   logic [CBITS-1:0]      w_cnt_inc;

   // Shift is applied before any same-cycle latch, which then sees the post-shift content.
   always_comb begin
      w_sr_next = r_sr;
      w_cnt_inc = r_cnt;
      if (w_sclk_rise) begin
         w_sr_next = {r_sr[WIDTH-2:0], w_pair};
         if (r_cnt != CBITS'(WIDTH)) begin
            w_cnt_inc = r_cnt + CBITS'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sr  <= '0;
         r_cnt <= '0;
      end else begin
         r_sr  <= w_sr_next;
         r_cnt <= w_latch_rise ? '0 : w_cnt_inc;
      end
   end

   state_t             r_state;
   state_t             w_state_next;
   logic               w_capture;
   logic               w_drop;
   logic               w_advance;
   logic               r_valid;
   logic               r_busy;
   logic [XBITS-1:0]   r_x;
   logic [ROWBITS-1:0] r_y;
   pix_pair_t          r_pix;
   logic               r_fs;
   logic               r_ovr;
   logic               r_short;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_capture    = 1'b0;
      w_drop       = 1'b0;
      w_advance    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_latch_rise) begin
               w_capture    = 1'b1;
               w_state_next = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            w_drop = w_latch_rise;
            if (out_ready) begin
               if (r_x == XBITS'(WIDTH - 1)) begin
                  w_state_next = ST_IDLE;
               end else begin
                  w_advance = 1'b1;
               end
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   // Line buffer shifts toward the top so r_line[WIDTH-1] is always the next pixel out.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_line  <= '0;
         r_valid <= 1'b0;
         r_busy  <= 1'b0;
         r_x     <= '0;
         r_y     <= '0;
         r_pix   <= '0;
         r_fs    <= 1'b0;
         r_ovr   <= 1'b0;
         r_short <= 1'b0;
      end else begin
         r_valid <= (w_state_next == ST_DRAIN);
         r_busy  <= (w_state_next == ST_DRAIN);
         r_fs    <= 1'b0;
         r_ovr   <= w_drop;
         r_short <= 1'b0;
         if (w_capture) begin
            r_line  <= {w_sr_next[WIDTH-2:0], 6'd0};
            r_pix   <= w_sr_next[WIDTH-1];
            r_x     <= '0;
            r_y     <= w_addry;
            r_short <= (w_cnt_inc < CBITS'(WIDTH));
            r_fs    <= (w_addry == '0);
         end else if (w_advance) begin
            r_line <= {r_line[WIDTH-2:0], 6'd0};
            r_pix  <= r_line[WIDTH-1];
            r_x    <= r_x + XBITS'(1);
         end
      end
   end

   assign out_valid   = r_valid;
   assign busy        = r_busy;
   assign out_x       = r_x;
   assign out_y       = r_y;
   assign out_rgb0    = r_pix.rgb0;
   assign out_rgb1    = r_pix.rgb1;
   assign blank_s     = w_blank;
   assign frame_start = r_fs;
   assign overrun     = r_ovr;
   assign short_line  = r_short;

endmodule

// File: tb/tb_hub75_rx.sv
// Directed bench for hub75_rx: panel model (last-64-shifted queue) plus a per-cycle pixel scoreboard.
module tb_hub75_rx;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       sclk, latch, blank;
   logic [4:0] addry;
   logic [2:0] rgb0, rgb1;
   logic       out_valid, out_ready;
   logic [5:0] out_x;
   logic [4:0] out_y;
   logic [2:0] out_rgb0, out_rgb1;
   logic       busy, blank_s, frame_start, overrun, short_line;

   hub75_rx dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .sclk        (sclk),
      .latch       (latch),
      .blank       (blank),
      .addry       (addry),
      .rgb0        (rgb0),
      .rgb1        (rgb1),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_x       (out_x),
      .out_y       (out_y),
      .out_rgb0    (out_rgb0),
      .out_rgb1    (out_rgb1),
      .busy        (busy),
      .blank_s     (blank_s),
      .frame_start (frame_start),
      .overrun     (overrun),
      .short_line  (short_line)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [5:0] x;
      logic [4:0] y;
      logic [5:0] pair;  // {rgb1,rgb0}
   } exp_t;

   exp_t       exp_q[$];
   logic [5:0] model_sr[$];  // oldest first: index k is the pixel for column x=k

   int n_checks = 0;
   int n_pass   = 0;
   int n_fs     = 0;
   int n_ovr    = 0;
   int n_short  = 0;
   int n_hs     = 0;
   int n_vcyc   = 0;
   int rmode    = 0;
   int rcnt     = 0;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, want);
   endtask

   task automatic model_reset();
      model_sr.delete();
      for (int i = 0; i < 64; i++) model_sr.push_back(6'd0);
   endtask

   task automatic clr_counts();
      n_fs = 0; n_ovr = 0; n_short = 0; n_hs = 0; n_vcyc = 0;
   endtask

   function automatic logic [5:0] basic_px(input int k);
      logic [2:0] v;
      v = 3'(k);
      return {~v, v};
   endfunction

   // Consumer ready: 0 = always, 1 = pattern 1,0,0,1, 2 = stalled.
   initial begin
      out_ready = 1'b0;
      forever begin
         @(posedge clk); #1;
         rcnt++;
         case (rmode)
            0:       out_ready = 1'b1;
            1:       out_ready = ((rcnt % 4) == 0) || ((rcnt % 4) == 3);
            default: out_ready = 1'b0;
         endcase
      end
   end

   // Scoreboard: every valid cycle must show the head of the expected queue.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (frame_start) n_fs++;
            if (overrun)     n_ovr++;
            if (short_line)  n_short++;
            if (out_valid) begin
               n_vcyc++;
               if (exp_q.size() == 0) begin
                  chk("spurious_valid", 32'(out_x), 32'hFFFF);
               end else begin
                  e = exp_q[0];
                  chk("pixel{x,y,rgb1,rgb0}", 32'({out_x, out_y, out_rgb1, out_rgb0}), 32'(e));
                  if (out_ready) begin
                     void'(exp_q.pop_front());
                     n_hs++;
                  end
               end
            end
         end
      end
   end

   task automatic shift_px(input logic [5:0] p);
      @(posedge clk); #1;
      rgb1 = p[5:3];
      rgb0 = p[2:0];
      @(posedge clk); #1;
      sclk = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      sclk = 1'b0;
      @(posedge clk);
      model_sr.push_back(p);
      if (model_sr.size() > 64) void'(model_sr.pop_front());
   endtask

   task automatic do_latch(input logic [4:0] y, input bit accept);
      @(posedge clk); #1;
      addry = y;
      @(posedge clk); #1;
      latch = 1'b1;
      if (accept) begin
         for (int k = 0; k < 64; k++) exp_q.push_back({6'(k), y, model_sr[k]});
      end
      repeat (2) @(posedge clk);
      #1;
      latch = 1'b0;
      repeat (2) @(posedge clk);
   endtask

   task automatic wait_drain(input string nm);
      bit done;
      done = 1'b0;
      for (int i = 0; i < 1500 && !done; i++) begin
         @(posedge clk); #2;
         if (exp_q.size() == 0 && !out_valid) done = 1'b1;
      end
      chk(nm, 32'(done), 32'd1);
   endtask

   initial begin
      bit found;
      rst_n = 1'b0; sclk = 1'b0; latch = 1'b0; blank = 1'b0;
      addry = '0; rgb0 = '0; rgb1 = '0;
      model_reset();

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_xy", 32'({out_x, out_y}), 32'd0);
      chk("rst_rgb", 32'({out_rgb1, out_rgb0}), 32'd0);
      chk("rst_pulses", 32'({frame_start, overrun, short_line, blank_s}), 32'd0);
      rst_n = 1'b1;
      clr_counts();
      repeat (6) @(posedge clk);
      #1;
      chk("post_rst_valid", 32'(out_valid), 32'd0);
      chk("post_rst_no_fs", 32'(n_fs), 32'd0);

      blank = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      chk("blank_s_high", 32'(blank_s), 32'd1);
      blank = 1'b0;

      // Basic line
      rmode = 0;
      for (int k = 0; k < 64; k++) shift_px(basic_px(k));
      chk("model_basic_x0", 32'(model_sr[0]), 32'h38);
      chk("model_basic_x63", 32'(model_sr[63]), 32'h07);
      clr_counts();
      do_latch(5'd5, 1'b1);
      wait_drain("basic_drain");
      chk("basic_valid_cycles", 32'(n_vcyc), 32'd64);
      chk("basic_handshakes", 32'(n_hs), 32'd64);
      chk("basic_no_short", 32'(n_short), 32'd0);
      chk("basic_no_fs", 32'(n_fs), 32'd0);

      // Backpressure
      rmode = 1;
      for (int k = 0; k < 64; k++) shift_px(basic_px(k));
      clr_counts();
      do_latch(5'd5, 1'b1);
      wait_drain("bp_drain");
      chk("bp_handshakes", 32'(n_hs), 32'd64);
      chk("bp_stalled", 32'(n_vcyc > 64), 32'd1);

      // Overrun: line A held by a stalled consumer, line B dropped
      rmode = 2;
      for (int k = 0; k < 64; k++) shift_px(6'(k + 3));
      clr_counts();
      do_latch(5'd3, 1'b1);
      for (int k = 0; k < 64; k++) shift_px(6'(k) ^ 6'h2a);
      do_latch(5'd4, 1'b0);
      repeat (4) @(posedge clk);
      #1;
      chk("ovr_pulse", 32'(n_ovr), 32'd1);
      chk("ovr_held_x0", 32'({out_valid, out_x}), 32'h40);
      rmode = 1;
      wait_drain("ovr_drain");
      chk("ovr_only_A", 32'(n_hs), 32'd64);

      // Short line: 40 shifts
      rmode = 0;
      for (int k = 0; k < 40; k++) shift_px(6'(k + 9));
      chk("model_short_23", 32'(model_sr[23]), 32'h15);
      chk("model_short_24", 32'(model_sr[24]), 32'd9);
      clr_counts();
      do_latch(5'd7, 1'b1);
      wait_drain("short_drain");
      chk("short_pulse", 32'(n_short), 32'd1);

      // Over-long line: 70 shifts, last 64 emitted
      for (int k = 0; k < 70; k++) shift_px(6'(k * 3));
      chk("model_long_0", 32'(model_sr[0]), 32'd18);
      chk("model_long_63", 32'(model_sr[63]), 32'd15);
      clr_counts();
      do_latch(5'd9, 1'b1);
      wait_drain("long_drain");
      chk("long_no_short", 32'(n_short), 32'd0);

      // Frame start on row 0 (no shifts, so also short)
      clr_counts();
      do_latch(5'd0, 1'b1);
      wait_drain("fs_drain");
      chk("fs_pulse", 32'(n_fs), 32'd1);
      chk("fs_short", 32'(n_short), 32'd1);

      // Reset mid-drain at x=30
      for (int k = 0; k < 64; k++) shift_px(basic_px(k));
      do_latch(5'd2, 1'b1);
      found = 1'b0;
      for (int i = 0; i < 400 && !found; i++) begin
         @(posedge clk); #2;
         if (out_valid && out_x == 6'd30) found = 1'b1;
      end
      chk("reached_x30", 32'(found), 32'd1);
      rst_n = 1'b0;
      exp_q.delete();
      model_reset();
      #1;
      chk("midrst_valid", 32'(out_valid), 32'd0);
      chk("midrst_busy_x", 32'({busy, out_x}), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      chk("midrst_idle", 32'(out_valid), 32'd0);
      for (int k = 0; k < 64; k++) shift_px(basic_px(k));
      clr_counts();
      do_latch(5'd6, 1'b1);
      wait_drain("after_rst_drain");
      chk("after_rst_cycles", 32'(n_vcyc), 32'd64);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
